// File: rtl/pc_packet_packer.sv
// Buffers 88-bit telemetry packets and frames each as 16-bit words (sync, seq header, payload).
// Optional trailing XOR checksum word when PC_PACKER_CHECKSUM_EN is defined.
module pc_packet_packer #(
  parameter logic [15:0] SYNC_WORD  = 16'hA55A,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [87:0] packet,
  input  logic        packet_valid,
  output logic [15:0] word_data,
  output logic [1:0]  word_be,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic [15:0] drop_count,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef PC_PACKER_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
`ifdef PC_PACKER_CHECKSUM_EN
    S_DATA  = 2'd2,
    S_CKSUM = 2'd3
`else
    S_DATA = 2'd2
`endif
  } state_t;

  // Word handshake: a word transfers on any cycle where word_valid & word_ready are both high;
  // word_data/word_be/word_last only change after such a transfer (or when a new frame starts).

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [87:0]   fifo_q [FIFO_DEPTH];
  logic [87:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   word_data_q, word_data_d, drop_count_q, drop_count_d;
  logic [1:0]    word_be_q, word_be_d;
  logic          word_valid_q, word_valid_d, word_last_q, word_last_d, busy_q, busy_d;
  logic          accept, pop, push, full, load;
  logic [87:0]   head;

  function automatic logic [15:0] frame_word(input logic [3:0] idx, input logic [87:0] pkt,
                                             input logic [7:0] seq);
    case (idx)
      4'd0:    frame_word = SYNC_WORD;
      4'd1:    frame_word = {seq, 8'h0B};
      4'd2:    frame_word = pkt[87:72];
      4'd3:    frame_word = pkt[71:56];
      4'd4:    frame_word = pkt[55:40];
      4'd5:    frame_word = pkt[39:24];
      4'd6:    frame_word = pkt[23:8];
      4'd7:    frame_word = {pkt[7:0], 8'h00};
      default: frame_word = SYNC_WORD ^ {seq, 8'h0B} ^ pkt[87:72] ^ pkt[71:56] ^ pkt[55:40]
                            ^ pkt[39:24] ^ pkt[23:8] ^ {pkt[7:0], 8'h00};
    endcase
  endfunction

  assign accept = word_valid_q & word_ready;
  assign pop    = accept & word_last_q;
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign push   = packet_valid & ~full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      seq_q        <= 8'd0;
      word_data_q  <= 16'd0;
      word_be_q    <= 2'b00;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      drop_count_q <= 16'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      seq_q        <= seq_d;
      word_data_q  <= word_data_d;
      word_be_q    <= word_be_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      drop_count_q <= drop_count_d;
      busy_q       <= busy_d;
    end
    fifo_q <= fifo_d;
  end

  // Next-state logic; a frame end chains straight into HDR only if a second entry is already stored.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        state_d = S_HDR;
        idx_d   = 4'd0;
        load    = 1'b1;
      end
      S_HDR: if (accept) begin
        load    = 1'b1;
        state_d = (idx_q == 4'd1) ? S_DATA : S_HDR;
        idx_d   = idx_q + 4'd1;
      end
      S_DATA: if (accept) begin
        load  = 1'b1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd7) begin
`ifdef PC_PACKER_CHECKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = (count_q > CW'(1)) ? S_HDR : S_IDLE;
          idx_d   = 4'd0;
`endif
        end
      end
`ifdef PC_PACKER_CHECKSUM_EN
      S_CKSUM: if (accept) begin
        load    = 1'b1;
        state_d = (count_q > CW'(1)) ? S_HDR : S_IDLE;
        idx_d   = 4'd0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wr_ptr_q] = packet;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    seq_d        = seq_q + 8'(pop);
    drop_count_d = drop_count_q;
    if (packet_valid && full && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    head         = fifo_q[rd_ptr_d];
    word_data_d  = word_data_q;
    word_be_d    = word_be_q;
    word_valid_d = word_valid_q;
    word_last_d  = word_last_q;
    if (load) begin
      word_valid_d = (state_d != S_IDLE);
      word_data_d  = word_valid_d ? frame_word(idx_d, head, seq_d) : 16'd0;
      word_be_d    = !word_valid_d ? 2'b00 : (idx_d == 4'd7) ? 2'b10 : 2'b11;
      word_last_d  = word_valid_d && (idx_d == LAST_IDX);
    end
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  assign word_data  = word_data_q;
  assign word_be    = word_be_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;
  assign drop_count = drop_count_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_packet_packer.sv
// Directed bench for pc_packet_packer: scoreboard of expected words, hold/gap checks on the stream.
module tb_pc_packet_packer;

  localparam logic [15:0] SYNC = 16'hA55A;
`ifdef PC_PACKER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam logic [87:0] P0 = 88'h0102030405060708090A0B;

  logic        clk = 1'b0;
  logic        rst;
  logic [87:0] packet;
  logic        packet_valid;
  logic [15:0] word_data;
  logic [1:0]  word_be;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic [15:0] drop_count;
  logic        busy;
  logic [1:0]  dbg_state;

  pc_packet_packer dut (
    .clk(clk), .rst(rst), .packet(packet), .packet_valid(packet_valid),
    .word_data(word_data), .word_be(word_be), .word_valid(word_valid),
    .word_ready(word_ready), .word_last(word_last), .drop_count(drop_count),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // scoreboard: entries are {last, be, data}
  logic [18:0] exp_q[$];
  logic [7:0]  model_seq;

  task automatic push_frame(input logic [87:0] p);
    logic [15:0] w [8];
    logic [15:0] cks;
    w[0] = SYNC;
    w[1] = {model_seq, 8'h0B};
    for (int k = 0; k < 5; k++) w[2+k] = p[87-16*k -: 16];
    w[7] = {p[7:0], 8'h00};
    cks = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      cks = cks ^ w[k];
      exp_q.push_back({(k == 7) && !CK, (k == 7) ? 2'b10 : 2'b11, w[k]});
    end
    if (CK) exp_q.push_back({1'b1, 2'b11, cks});
    model_seq = model_seq + 8'd1;
  endtask

  // monitor
  logic        mon_hold;
  logic        gap_pending;
  logic [18:0] held;
  logic [18:0] mon_e;
  logic [15:0] last_w1;
  int          word_idx;

  always @(negedge clk) begin
    if (rst) begin
      mon_hold    = 1'b0;
      gap_pending = 1'b0;
      word_idx    = 0;
    end else begin
      if (gap_pending) begin
        check("no_gap_valid", 32'(word_valid), 32'd1);
        gap_pending = 1'b0;
      end
      if (mon_hold) check("hold_stable", 32'({word_last, word_be, word_data}), 32'(held));
      mon_hold = 1'b0;
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", 32'(word_data), 32'hFFFF_FFFF);
        else begin
          mon_e = exp_q.pop_front();
          check("word", 32'({word_last, word_be, word_data}), 32'(mon_e));
        end
        if (word_idx == 1) last_w1 = word_data;
        if (word_last) begin
          word_idx = 0;
          if (exp_q.size() != 0) gap_pending = 1'b1;
        end else word_idx++;
      end else if (word_valid) begin
        mon_hold = 1'b1;
        held     = {word_last, word_be, word_data};
      end
    end
  end

  // driver tasks
  task automatic send(input logic [87:0] p);
    @(posedge clk); #1;
    packet = p;
    packet_valid = 1'b1;
    @(posedge clk); #1;
    packet_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit toggle);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !word_valid) return;
      if (toggle) word_ready = ~word_ready;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_seq = 8'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    packet = P0;
    packet_valid = 1'b1;
    word_ready = 1'b0;
    model_seq = 8'd0;
    last_w1 = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(word_valid), 32'd0);
    check("reset_data", 32'(word_data), 32'd0);
    check("reset_be", 32'(word_be), 32'd0);
    check("reset_last", 32'(word_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_drop", 32'(drop_count), 32'd0);
    rst = 1'b0;
    packet_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ignores_strobe_valid", 32'(word_valid), 32'd0);
    check("rst_ignores_strobe_busy", 32'(busy), 32'd0);

    // single packet, latency N+2
    word_ready = 1'b1;
    @(posedge clk); #1;
    packet = P0;
    packet_valid = 1'b1;
    push_frame(P0);
    @(posedge clk); #1;
    packet_valid = 1'b0;
    check("lat_n1_valid", 32'(word_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_n2_valid", 32'(word_valid), 32'd1);
    check("lat_n2_w0", 32'(word_data), 32'(SYNC));
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_drain(40, 1'b0);
    check("single_w1", 32'(last_w1), 32'h000B);
    check("idle_busy", 32'(busy), 32'd0);

    // backpressure, ready toggling every cycle
    push_frame(88'hDEADBEEF_CAFEF00D_123456);
    send(88'hDEADBEEF_CAFEF00D_123456);
    wait_drain(80, 1'b1);
    word_ready = 1'b1;

    // overflow: four strobes while stalled
    word_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      packet = {8'(i), 80'h1111_2222_3333_4444_5555};
      packet_valid = 1'b1;
      if (i < 2) push_frame(packet);
      @(posedge clk); #1;
    end
    packet_valid = 1'b0;
    @(posedge clk); #1;
    check("overflow_drop", 32'(drop_count), 32'd2);
    check("overflow_stalled_valid", 32'(word_valid), 32'd1);
    word_ready = 1'b1;
    wait_drain(80, 1'b0);
    check("overflow_drop_after", 32'(drop_count), 32'd2);

    // back-to-back from a full FIFO
    word_ready = 1'b0;
    push_frame(88'hA0A1A2A3A4A5A6A7A8A9AA);
    send(88'hA0A1A2A3A4A5A6A7A8A9AA);
    push_frame(88'hB0B1B2B3B4B5B6B7B8B9BA);
    send(88'hB0B1B2B3B4B5B6B7B8B9BA);
    word_ready = 1'b1;
    wait_drain(80, 1'b0);

    // reset mid-frame while W4 is presented
    push_frame(P0);
    send(P0);
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (word_valid && word_data == 16'h0506) found = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("midframe_w4_seen", 32'(found), 32'd1);
    end
    word_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    model_seq = 8'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_data", 32'(word_data), 32'd0);
    check("midrst_be", 32'(word_be), 32'd0);
    check("midrst_last", 32'(word_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    word_ready = 1'b1;
    push_frame(P0);
    send(P0);
    wait_drain(40, 1'b0);
    check("midrst_seq0", 32'(last_w1), 32'h000B);

    // seq wrap over 257 frames
    do_reset();
    word_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      packet = {8'(i), 80'h0};
      push_frame({8'(i), 80'h0});
      send({8'(i), 80'h0});
      wait_drain(40, 1'b0);
      if (i == 255) check("wrap_frame256_w1", 32'(last_w1), 32'hFF0B);
      if (i == 256) check("wrap_frame257_w1", 32'(last_w1), 32'h000B);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
